// File: rtl/pe_control_unit_pkg.sv
// Shared coprocessor definitions: data width, default geometry and PE FSM encodings.
package pe_control_unit_pkg;

    // Datapath width of matrix elements and of the accumulator.
    localparam int unsigned DataW        = 32;

    // Default geometry shared with the main control unit.
    localparam int unsigned DefaultAddrW = 16;
    localparam int unsigned DefaultDimW  = 8;

    // Processing-element FSM encodings.
    localparam int unsigned StateW = 3;
    typedef logic [StateW-1:0] pe_state_t;

    localparam pe_state_t StIdle    = 3'd0;
    localparam pe_state_t StLoad    = 3'd1;
    localparam pe_state_t StRequest = 3'd2;
    localparam pe_state_t StReadA   = 3'd3;
    localparam pe_state_t StReadB   = 3'd4;
    localparam pe_state_t StMac     = 3'd5;
    localparam pe_state_t StWrite   = 3'd6;
    localparam pe_state_t StDone    = 3'd7;

    // True for every state in which the PE owns (or is asking for) the memory bus.
    function automatic logic state_holds_bus(input pe_state_t st);
        return (st == StRequest) || (st == StReadA) || (st == StReadB) ||
               (st == StMac)     || (st == StWrite);
    endfunction

endpackage

// File: rtl/pe_mac.sv
// Signed 32x32 multiply-accumulate: captures the A operand, then adds A*B into the accumulator.
module pe_mac
    import pe_control_unit_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_a_i,
    input  logic             mac_en_i,
    input  logic [DataW-1:0] operand_i,
    output logic [DataW-1:0] acc_o
);

    logic [DataW-1:0] a_q, a_d;
    logic [DataW-1:0] acc_q, acc_d;
    logic [DataW-1:0] product;

    // The low half of a two's-complement product is identical for signed and unsigned
    // operands, so a plain width-matched multiply gives the wrapped signed result.
    assign product = a_q * operand_i;

    // Next-state: clear wins, otherwise capture A and/or accumulate A*B.
    always_comb begin
        a_d   = a_q;
        acc_d = acc_q;
        if (clear_i) begin
            a_d   = '0;
            acc_d = '0;
        end else begin
            if (load_a_i) begin
                a_d = operand_i;
            end
            if (mac_en_i) begin
                acc_d = acc_q + product;
            end
        end
    end

    // Operand and accumulator registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/pe_control_unit.sv
// Processing element controller: fetches row r of A and column c of B over a shared,
// arbitrated memory bus, accumulates their dot product and writes C[r][c].
module pe_control_unit
    import pe_control_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = DefaultAddrW,
    parameter int unsigned DIM_W  = DefaultDimW
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    // Job offer from the main control unit
    input  logic              i_Indexes_Ready,
    input  logic [DIM_W-1:0]  i_Row_Index,
    input  logic [DIM_W-1:0]  i_Column_Index,
    input  logic [DIM_W-1:0]  i_Dimension,
    input  logic [ADDR_W-1:0] i_A_Base,
    input  logic [ADDR_W-1:0] i_B_Base,
    input  logic [ADDR_W-1:0] i_C_Base,
    output logic              o_Indexes_Received,
    // Bus arbitration
    output logic              o_Grant_Request,
    input  logic              i_Grant,
    // Synchronous memory port
    output logic [ADDR_W-1:0] o_Mem_Address,
    output logic              o_Mem_Write_Enable,
    output logic [DataW-1:0]  o_Mem_Write_Data,
    input  logic [DataW-1:0]  i_Mem_Read_Data,
    // Completion handshake
    output logic              o_Result_Ready,
    input  logic              i_Result_Ack
);

    pe_state_t         state_q, state_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [DIM_W-1:0]  dim_q, dim_d;
    logic [DIM_W-1:0]  k_q, k_d;
    logic [ADDR_W-1:0] a_base_q, a_base_d;
    logic [ADDR_W-1:0] b_base_q, b_base_d;
    logic [ADDR_W-1:0] c_base_q, c_base_d;
    logic [ADDR_W-1:0] a_ptr_q, a_ptr_d;
    logic [ADDR_W-1:0] b_ptr_q, b_ptr_d;
    logic [ADDR_W-1:0] c_ptr_q, c_ptr_d;
    logic              idx_rcvd_q, idx_rcvd_d;

    logic              mac_clear;
    logic              mac_load_a;
    logic              mac_en;
    logic [DataW-1:0]  acc;
    logic [DIM_W-1:0]  k_inc;
    logic [2*DIM_W-1:0] row_off;

    // Full-width r*N so the row offset is not truncated before it reaches ADDR_W.
    assign row_off = (2*DIM_W)'(row_q) * (2*DIM_W)'(dim_q);
    assign k_inc   = k_q + DIM_W'(1);

    // FSM and pointer next-state. A missing grant in any bus state retreats to REQUEST
    // without side effects, so the same k is re-read once the bus comes back.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        dim_d      = dim_q;
        k_d        = k_q;
        a_base_d   = a_base_q;
        b_base_d   = b_base_q;
        c_base_d   = c_base_q;
        a_ptr_d    = a_ptr_q;
        b_ptr_d    = b_ptr_q;
        c_ptr_d    = c_ptr_q;
        idx_rcvd_d = 1'b0;
        mac_clear  = 1'b0;
        mac_load_a = 1'b0;
        mac_en     = 1'b0;

        case (state_q)
            StIdle: begin
                if (i_Indexes_Ready) begin
                    row_d      = i_Row_Index;
                    col_d      = i_Column_Index;
                    dim_d      = i_Dimension;
                    a_base_d   = i_A_Base;
                    b_base_d   = i_B_Base;
                    c_base_d   = i_C_Base;
                    idx_rcvd_d = 1'b1;
                    state_d    = StLoad;
                end
            end

            StLoad: begin
                a_ptr_d   = a_base_q + ADDR_W'(row_off);
                b_ptr_d   = b_base_q + ADDR_W'(col_q);
                c_ptr_d   = c_base_q + ADDR_W'(row_off) + ADDR_W'(col_q);
                k_d       = '0;
                mac_clear = 1'b1;
                state_d   = StRequest;
            end

            StRequest: begin
                // k == N covers both N = 0 and a grant lost during WRITE.
                if (i_Grant) begin
                    state_d = (k_q == dim_q) ? StWrite : StReadA;
                end
            end

            StReadA: begin
                state_d = i_Grant ? StReadB : StRequest;
            end

            StReadB: begin
                if (i_Grant) begin
                    mac_load_a = 1'b1;
                    state_d    = StMac;
                end else begin
                    state_d = StRequest;
                end
            end

            StMac: begin
                if (i_Grant) begin
                    mac_en  = 1'b1;
                    k_d     = k_inc;
                    a_ptr_d = a_ptr_q + ADDR_W'(1);
                    b_ptr_d = b_ptr_q + ADDR_W'(dim_q);
                    state_d = (k_inc == dim_q) ? StWrite : StReadA;
                end else begin
                    state_d = StRequest;
                end
            end

            StWrite: begin
                state_d = i_Grant ? StDone : StRequest;
            end

            StDone: begin
                if (i_Result_Ack) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // State, job registers and pointers; reset aborts any job in flight.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q    <= StIdle;
            row_q      <= '0;
            col_q      <= '0;
            dim_q      <= '0;
            k_q        <= '0;
            a_base_q   <= '0;
            b_base_q   <= '0;
            c_base_q   <= '0;
            a_ptr_q    <= '0;
            b_ptr_q    <= '0;
            c_ptr_q    <= '0;
            idx_rcvd_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            dim_q      <= dim_d;
            k_q        <= k_d;
            a_base_q   <= a_base_d;
            b_base_q   <= b_base_d;
            c_base_q   <= c_base_d;
            a_ptr_q    <= a_ptr_d;
            b_ptr_q    <= b_ptr_d;
            c_ptr_q    <= c_ptr_d;
            idx_rcvd_q <= idx_rcvd_d;
        end
    end

    // Datapath: A is captured in READ_B, B arrives on the read bus during MAC.
    pe_mac u_pe_mac (
        .clk_i     (i_Clock),
        .rst_ni    (i_Reset_n),
        .clear_i   (mac_clear),
        .load_a_i  (mac_load_a),
        .mac_en_i  (mac_en),
        .operand_i (i_Mem_Read_Data),
        .acc_o     (acc)
    );

    // Outputs: the memory port is gated by i_Grant so a lost grant never issues an access.
    always_comb begin
        o_Indexes_Received = idx_rcvd_q;
        o_Grant_Request    = state_holds_bus(state_q);
        o_Result_Ready     = (state_q == StDone);
        o_Mem_Address      = '0;
        o_Mem_Write_Enable = 1'b0;
        o_Mem_Write_Data   = '0;
        if (i_Grant) begin
            case (state_q)
                StReadA: o_Mem_Address = a_ptr_q;
                StReadB: o_Mem_Address = b_ptr_q;
                StWrite: begin
                    o_Mem_Address      = c_ptr_q;
                    o_Mem_Write_Enable = 1'b1;
                    o_Mem_Write_Data   = acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_control_unit.sv
// Directed bench for pe_control_unit with a synchronous memory model and hand-computed results.
module tb_pe_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready;
    logic [7:0]  row, col, dim;
    logic [15:0] a_base, b_base, c_base;
    logic        idx_rcvd;
    logic        gnt_req;
    logic        gnt;
    logic [15:0] mem_addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata = '0;
    logic        res_rdy;
    logic        ack;

    logic [31:0] mem [65536];

    int          cyc    = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [15:0] wr_addr = '0;
    logic [31:0] wr_data = '0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pe_control_unit dut (
        .i_Clock            (clk),
        .i_Reset_n          (rst_n),
        .i_Indexes_Ready    (ready),
        .i_Row_Index        (row),
        .i_Column_Index     (col),
        .i_Dimension        (dim),
        .i_A_Base           (a_base),
        .i_B_Base           (b_base),
        .i_C_Base           (c_base),
        .o_Indexes_Received (idx_rcvd),
        .o_Grant_Request    (gnt_req),
        .i_Grant            (gnt),
        .o_Mem_Address      (mem_addr),
        .o_Mem_Write_Enable (we),
        .o_Mem_Write_Data   (wdata),
        .i_Mem_Read_Data    (rdata),
        .o_Result_Ready     (res_rdy),
        .i_Result_Ack       (ack)
    );

    // Memory model: read data one cycle after the address; writes are logged, not stored.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdata <= mem[mem_addr];
        if (we) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= wdata;
        end
        if (gnt_req && gnt && !we && mem_addr != 16'h0000) begin
            rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    // Offer one job and follow it to completion. drop_addr != 0 removes the grant in the
    // cycle that address appears, and keeps it away for three further REQUEST cycles.
    task automatic run_job(input string tag, input logic [7:0] r, input logic [7:0] c,
                           input logic [7:0] n, input logic [15:0] ab, input logic [15:0] bb,
                           input logic [15:0] cb, input logic [15:0] drop_addr,
                           input int ack_delay, input bit hold_ready, input int exp_lat,
                           input logic [15:0] exp_addr, input logic [31:0] exp_data);
        int guard;
        int pulse_cyc;
        int w0;
        int extra;
        int hold_cnt;
        bit dropped;
        row = r; col = c; dim = n; a_base = ab; b_base = bb; c_base = cb;
        ready = 1'b1;
        w0 = wr_cnt;
        guard = 0;
        while (!idx_rcvd && guard < 20) begin
            tick();
            guard++;
        end
        check_eq({tag, ":accept"}, 32'(idx_rcvd), 32'd1);
        if (!idx_rcvd) return;
        pulse_cyc = cyc;
        if (!hold_ready) ready = 1'b0;

        guard = 0; extra = 0; dropped = 1'b0;
        while (!res_rdy && guard < 200) begin
            if (drop_addr != 16'h0000 && !dropped && mem_addr == drop_addr) begin
                gnt = 1'b0;
                #1;
                check_eq({tag, ":drop_no_access"}, 32'(mem_addr), 32'h0);
                check_eq({tag, ":drop_req"}, 32'(gnt_req), 32'd1);
                for (int i = 0; i < 4; i++) begin
                    tick();
                    check_eq({tag, ":wait_req"}, 32'(gnt_req), 32'd1);
                end
                gnt = 1'b1;
                dropped = 1'b1;
            end
            tick();
            guard++;
            if (idx_rcvd) extra++;
        end
        if (drop_addr != 16'h0000) check_eq({tag, ":dropped"}, 32'(dropped), 32'd1);
        check_eq({tag, ":ready"}, 32'(res_rdy), 32'd1);
        check_eq({tag, ":latency"}, 32'(cyc - pulse_cyc + 1), 32'(exp_lat));
        check_eq({tag, ":req_off"}, 32'(gnt_req), 32'd0);
        check_eq({tag, ":wr_count"}, 32'(wr_cnt - w0), 32'd1);
        check_eq({tag, ":wr_addr"}, 32'(wr_addr), 32'(exp_addr));
        check_eq({tag, ":wr_data"}, wr_data, exp_data);

        hold_cnt = 1;
        for (int i = 0; i < ack_delay; i++) begin
            tick();
            if (res_rdy) hold_cnt++;
            if (idx_rcvd) extra++;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_eq({tag, ":ready_hold"}, 32'(hold_cnt), 32'(ack_delay + 1));
        check_eq({tag, ":ready_clr"}, 32'(res_rdy), 32'd0);
        check_eq({tag, ":one_pulse"}, 32'(extra), 32'd0);
    endtask

    initial begin
        int guard;
        int w0;
        int r0;
        for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);          // A = [[1,2],[3,4]]
        for (int i = 0; i < 4; i++) mem[16 + i] = 32'(i + 5);     // B = [[5,6],[7,8]]
        mem[16'h30] = 32'h7FFF_FFFF;
        mem[16'h31] = 32'h0000_0002;

        rst_n = 1'b0; gnt = 1'b1; ack = 1'b0;
        // Job offered already during reset; it must wait for a clock edge after release.
        ready = 1'b1; row = 8'd1; col = 8'd0; dim = 8'd2;
        a_base = 16'h00; b_base = 16'h10; c_base = 16'h20;
        #1;
        check_eq("rst_req", 32'(gnt_req), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'h0);
        check_eq("rst_we", 32'(we), 32'd0);
        check_eq("rst_rdy", 32'(res_rdy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("rel_no_accept", 32'(idx_rcvd), 32'd0);

        // C[1][0] = 3*5 + 4*7 = 43 at 0x20 + 1*2 + 0
        run_job("basic", 8'd1, 8'd0, 8'd2, 16'h00, 16'h10, 16'h20, 16'h0, 0, 1'b0,
                10, 16'h22, 32'd43);

        // N = 0: no reads, zero written to C_Base
        r0 = rd_cnt;
        run_job("n0", 8'd0, 8'd0, 8'd0, 16'h40, 16'h50, 16'h60, 16'h0, 1, 1'b0,
                4, 16'h60, 32'd0);
        check_eq("n0:no_reads", 32'(rd_cnt - r0), 32'd0);

        // Grant lost while B[1][0] (0x12) is addressed: 10 + 3 + 2 + 1 cycles
        run_job("drop", 8'd1, 8'd0, 8'd2, 16'h00, 16'h10, 16'h20, 16'h12, 0, 1'b0,
                16, 16'h22, 32'd43);

        // 0x7FFFFFFF * 2 wraps to 0xFFFFFFFE
        run_job("wrap", 8'd0, 8'd0, 8'd1, 16'h30, 16'h31, 16'h38, 16'h0, 0, 1'b0,
                7, 16'h38, 32'hFFFF_FFFE);

        // Reset asserted mid-cycle during MAC of k = 0
        row = 8'd1; col = 8'd0; dim = 8'd2;
        a_base = 16'h00; b_base = 16'h10; c_base = 16'h20;
        ready = 1'b1;
        guard = 0;
        while (!idx_rcvd && guard < 20) begin tick(); guard++; end
        ready = 1'b0;
        guard = 0;
        while (mem_addr != 16'h10 && guard < 20) begin tick(); guard++; end
        check_eq("mrst:reach_read_b", 32'(mem_addr), 32'h10);
        tick();
        w0 = wr_cnt;
        #2 rst_n = 1'b0;
        #1;
        check_eq("mrst:req", 32'(gnt_req), 32'd0);
        check_eq("mrst:addr", 32'(mem_addr), 32'h0);
        check_eq("mrst:we", 32'(we), 32'd0);
        check_eq("mrst:wdata", wdata, 32'h0);
        check_eq("mrst:rdy", 32'(res_rdy), 32'd0);
        check_eq("mrst:idx", 32'(idx_rcvd), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_eq("mrst:no_write", 32'(wr_cnt - w0), 32'd0);
        run_job("after_rst", 8'd1, 8'd0, 8'd2, 16'h00, 16'h10, 16'h20, 16'h0, 0, 1'b0,
                10, 16'h22, 32'd43);

        // Ready held high across the job, ack after 5 cycles, back-to-back acceptance
        run_job("hold", 8'd1, 8'd0, 8'd2, 16'h00, 16'h10, 16'h20, 16'h0, 5, 1'b1,
                10, 16'h22, 32'd43);
        tick();
        check_eq("hold:next_accept", 32'(idx_rcvd), 32'd1);
        run_job("hold2", 8'd1, 8'd0, 8'd2, 16'h00, 16'h10, 16'h20, 16'h0, 0, 1'b0,
                10, 16'h22, 32'd43);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
